// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Shared definitions for the MIPS execute stage: MDU op
//                encoding plus default datapath width and MDU latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

    localparam int DEFAULT_WIDTH       = 32;
    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MFHI  = 3'd4,
        MDU_MFLO  = 3'd5,
        MDU_MTHI  = 3'd6,
        MDU_MTLO  = 3'd7
    } mdu_op_e;

    // Ops 0-3 are the multi-cycle arithmetic ops; 4-7 are moves.
    function automatic logic mdu_is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Request/response bundle between the execute-stage
//                controller (master) and the multiply/divide unit (slave).
//                  start, op, A, B : request from controller
//                  busy, hi, lo, out : status and read data from the MDU
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if
    import mips_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;

    modport master (
        output start, op, A, B,
        input  busy, hi, lo, out
    );

    modport slave (
        input  start, op, A, B,
        output busy, hi, lo, out
    );

endinterface
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Purely combinational multiply/divide core. Produces the
//                2*WIDTH result {res_hi,res_lo} for MULT/MULTU/DIV/DIVU,
//                including the divide-by-zero and signed-overflow results.
//                  op, A, B        : operation and operands
//                  res_hi, res_lo  : result halves (zero for move ops)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mips_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] c_ones    = '1;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] w_smul;
    logic [2*WIDTH-1:0] w_umul;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_sq;
    logic [WIDTH-1:0]   w_sr;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic               w_div_zero;
    logic               w_ovf;

    assign w_smul = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
    assign w_umul = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    assign w_div_zero = (B == '0);
    assign w_ovf      = (op == MDU_DIV) && (A == c_min_neg) && (B == c_ones);

    // The two special cases are resolved by the mux below; steer the divider
    // away from them so it never sees a zero divisor or an overflowing pair.
    assign w_divisor = (w_div_zero || w_ovf) ? c_one : B;

    assign w_sq = $signed(A) / $signed(w_divisor);
    assign w_sr = $signed(A) % $signed(w_divisor);
    assign w_uq = A / w_divisor;
    assign w_ur = A % w_divisor;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = w_smul;
            MDU_MULTU: {res_hi, res_lo} = w_umul;
            MDU_DIV: begin
                if (w_div_zero) begin
                    res_hi = A;
                    res_lo = c_ones;
                end else if (w_ovf) begin
                    res_hi = '0;
                    res_lo = A;
                end else begin
                    res_hi = w_sr;
                    res_lo = w_sq;
                end
            end
            MDU_DIVU: begin
                if (w_div_zero) begin
                    res_hi = A;
                    res_lo = c_ones;
                end else begin
                    res_hi = w_ur;
                    res_lo = w_uq;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Multi-cycle multiply/divide unit with the HI/LO pair.
//                The result is computed at the accept edge, parked in the
//                pending registers and committed to HI/LO when the latency
//                counter expires.
//                  clk, reset : clock, synchronous active-high reset
//                  bus        : mdu_if slave (start/op/A/B in,
//                               busy/hi/lo/out out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
    import mips_defs::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);

    localparam int c_max_lat = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);

    localparam logic [c_cnt_w-1:0] c_mult_lat = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_lat  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_pend_hi;
    logic [WIDTH-1:0]   r_pend_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic               w_idle_start;
    logic               w_accept;
    logic               w_done;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (bus.op),
        .A      (bus.A),
        .B      (bus.B),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    // Every request is dropped while an operation is in flight.
    assign w_idle_start = bus.start && (r_state == c_st_idle);
    assign w_accept     = w_idle_start && mdu_is_arith(bus.op);
    assign w_done       = (r_state == c_st_busy) && (r_count == c_cnt_one);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_nxt = c_st_busy;
            c_st_busy: if (w_done)   w_state_nxt = c_st_idle;
            default:                 w_state_nxt = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = (r_state == c_st_busy);
        bus.hi   = r_hi;
        bus.lo   = r_lo;
        bus.out  = '0;
        if (bus.op == MDU_MFHI) begin
            bus.out = r_hi;
        end else if (bus.op == MDU_MFLO) begin
            bus.out = r_lo;
        end
    end

    // ---------------- Datapath: counter, pending and HI/LO ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_accept) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_count   <= bus.op[1] ? c_div_lat : c_mult_lat;
        end else if (r_state == c_st_busy) begin
            r_count <= r_count - c_cnt_one;
            if (w_done) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_idle_start && (bus.op == MDU_MTHI)) begin
            r_hi <= bus.A;
        end else if (w_idle_start && (bus.op == MDU_MTLO)) begin
            r_lo <= bus.A;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu: directed vector table,
//                hand-written multi-cycle sequences and randomized ops
//                compared against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
    import mips_defs::*;

    localparam int W  = 32;
    localparam int NM = 5;
    localparam int ND = 10;

    logic clk = 1'b0;
    logic reset;

    mdu_if #(.WIDTH(W)) mif ();

    mdu #(
        .WIDTH       (W),
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then count the cycles busy stays high (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        mif.start = 1'b1;
        mif.op    = op;
        mif.A     = a;
        mif.B     = b;
        tick();
        mif.start = 1'b0;
        mif.op    = MDU_MULT;
        mif.A     = $urandom;
        mif.B     = $urandom;
        cyc = 0;
        while (mif.busy && cyc < 100) begin
            cyc++;
            tick();
        end
    endtask

    // Reference result {hi,lo} from ordinary 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        q  = 0;
        r  = 0;
        case (op)
            MDU_MULT:  return sa * sb;
            MDU_MULTU: return ua * ub;
            MDU_DIV, MDU_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (op == MDU_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] m;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, NM};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, NM};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, ND};
        vecs[3] = '{MDU_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, ND};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, ND};
        vecs[5] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, ND};
        vecs[6] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, ND};
        vecs[7] = '{MDU_DIV,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, ND};

        // ---------------- reset state ----------------
        reset     = 1'b1;
        mif.start = 1'b0;
        mif.op    = MDU_MFHI;
        mif.A     = '0;
        mif.B     = '0;
        tick();
        tick();
        chk("reset_busy", {63'h0, mif.busy}, 64'h0);
        chk("reset_hi",   {32'h0, mif.hi},   64'h0);
        chk("reset_lo",   {32'h0, mif.lo},   64'h0);
        chk("reset_out",  {32'h0, mif.out},  64'h0);
        reset = 1'b0;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d_hi", i), {32'h0, mif.hi}, {32'h0, vecs[i].exp_hi});
            chk($sformatf("vec%0d_lo", i), {32'h0, mif.lo}, {32'h0, vecs[i].exp_lo});
            mif.op = MDU_MFHI;
            #1;
            chk($sformatf("vec%0d_mfhi", i), {32'h0, mif.out}, {32'h0, vecs[i].exp_hi});
            mif.op = MDU_MFLO;
            #1;
            chk($sformatf("vec%0d_mflo", i), {32'h0, mif.out}, {32'h0, vecs[i].exp_lo});
            mif.op = MDU_MTHI;
            #1;
            chk($sformatf("vec%0d_out_other", i), {32'h0, mif.out}, 64'h0);
        end

        // ---------------- start while busy ----------------
        mif.start = 1'b1;
        mif.op    = MDU_MULT;
        mif.A     = 32'd3;
        mif.B     = 32'd4;
        tick();
        cyc = 0;
        while (mif.busy && cyc < 100) begin
            cyc++;
            mif.start = 1'b1;
            if (cyc == 1) begin
                mif.op = MDU_MTLO;
                mif.A  = 32'h1234;
            end else begin
                mif.op = MDU_MULT;
                mif.A  = 32'd100;
                mif.B  = 32'd100;
            end
            tick();
        end
        mif.start = 1'b0;
        chk("busyign_cycles", 64'(cyc), 64'(NM));
        chk("busyign_hi", {32'h0, mif.hi}, 64'h0);
        chk("busyign_lo", {32'h0, mif.lo}, 64'd12);

        // Next op immediately after busy falls must be accepted.
        run_op(MDU_MULTU, 32'd7, 32'd6, cyc);
        chk("b2b_cycles", 64'(cyc), 64'(NM));
        chk("b2b_lo", {32'h0, mif.lo}, 64'd42);

        // ---------------- MTHI / MTLO ----------------
        mif.start = 1'b1;
        mif.op    = MDU_MTHI;
        mif.A     = 32'hAAAA_0000;
        tick();
        chk("mthi_busy", {63'h0, mif.busy}, 64'h0);
        chk("mthi_hi", {32'h0, mif.hi}, 64'hAAAA_0000);
        chk("mthi_lo_kept", {32'h0, mif.lo}, 64'd42);
        mif.op = MDU_MTLO;
        mif.A  = 32'h5555;
        tick();
        mif.start = 1'b0;
        chk("mtlo_busy", {63'h0, mif.busy}, 64'h0);
        chk("mtlo_hi_kept", {32'h0, mif.hi}, 64'hAAAA_0000);
        chk("mtlo_lo", {32'h0, mif.lo}, 64'h5555);

        // ---------------- reset mid-operation ----------------
        mif.start = 1'b1;
        mif.op    = MDU_DIV;
        mif.A     = 32'd100;
        mif.B     = 32'd7;
        tick();
        mif.start = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", {63'h0, mif.busy}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", {63'h0, mif.busy}, 64'h0);
        chk("midrst_hi", {32'h0, mif.hi}, 64'h0);
        chk("midrst_lo", {32'h0, mif.lo}, 64'h0);
        repeat (ND + 2) tick();
        chk("midrst_late_busy", {63'h0, mif.busy}, 64'h0);
        chk("midrst_late_hi", {32'h0, mif.hi}, 64'h0);
        chk("midrst_late_lo", {32'h0, mif.lo}, 64'h0);

        // ---------------- randomized ops vs reference model ----------------
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7, 0))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       ra = 32'h8000_0000;
                3:       rb = 32'($urandom_range(15, 1));
                default: ;
            endcase
            m = model(rop, ra, rb);
            run_op(rop, ra, rb, cyc);
            chk($sformatf("rnd%0d_op%0d_cycles", i, rop), 64'(cyc),
                64'(((rop == MDU_DIV) || (rop == MDU_DIVU)) ? ND : NM));
            chk($sformatf("rnd%0d_op%0d_hi a=%0h b=%0h", i, rop, ra, rb),
                {32'h0, mif.hi}, {32'h0, m[63:32]});
            chk($sformatf("rnd%0d_op%0d_lo a=%0h b=%0h", i, rop, ra, rb),
                {32'h0, mif.lo}, {32'h0, m[31:0]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit holding the HI/LO register pair for the next-generation MIPS datapath. It sits beside the ALU in the execute stage, takes the two register-file read operands, and runs MULT/MULTU/DIV/DIVU over a configurable number of cycles. It also serves MFHI/MFLO/MTHI/MTLO, and reports `busy` so the controller can stall dependent instructions.

## Interface
- `WIDTH`, 32: operand, HI and LO width in bits.
- `MULT_CYCLES`, 5: multiply latency in cycles, must be ≥1.
- `DIV_CYCLES`, 10: divide latency in cycles, must be ≥1.
- `clk`  in  1  the single clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  qualifies `op` this cycle.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `A`  in  WIDTH  operand rs; also the write data for MTHI/MTLO.
- `B`  in  WIDTH  operand rt.
- `busy`  out  1  a multiply/divide is in flight.
- `hi`  out  WIDTH  current HI register.
- `lo`  out  WIDTH  current LO register.
- `out`  out  WIDTH  read data: `hi` when `op`=MFHI, `lo` when `op`=MFLO, else 0. Combinational; does not depend on `start`.

## Operation
- Reset values: `busy`=0, `hi`=0, `lo`=0, cycle counter=0, pending result registers=0.
- **Accept rule:** `start`=1 with `op` in 0–3 and `busy`=0 is accepted at that edge. The unit latches the 2·WIDTH result into `pend_hi`/`pend_lo` and loads the counter with the op latency.
- **MULT:** `{hi,lo}` = signed A×B, full 2·WIDTH product.
- **MULTU:** `{hi,lo}` = unsigned A×B, full 2·WIDTH product.
- **DIV:** `lo` = quotient and `hi` = remainder. Signed, truncating toward zero; the remainder takes the sign of A.
- **DIVU:** as DIV, unsigned.
- **Divide by zero (B=0):** `lo`=all-ones, `hi`=A, for both DIV and DIVU.
- **Signed overflow:** DIV with A=most-negative and B=−1 gives `lo`=A, `hi`=0.
- **Counter:** decrements each cycle while `busy`. On the edge where the counter goes 1→0, `hi`/`lo` load from pending and `busy` falls.
- **MTHI/MTLO:** with `start`=1 and `busy`=0, A is written into `hi`/`lo` at the edge. The other register is unchanged.
- **`start` while `busy`=1:** ignored for every op, no state change. The controller must stall.
- MFHI/MFLO never modify state. During `busy`, `out` returns the old HI/LO value; the controller must stall these as well.
- **Reset mid-operation:** the operation is aborted, `busy`=0, and HI/LO are cleared to 0. No late write-back occurs.

## Timing
- An op accepted at edge t0 gives `busy`=1 from after t0 through the cycle before edge t0+N, where N is the op latency. That is exactly N cycles high.
- `hi`/`lo` show the new result after edge t0+N; `busy`=0 at the same edge.
- A new `start` is accepted at edge t0+N+1 at the earliest. Back-to-back ops therefore have N+1 cycle spacing.
- MTHI/MTLO take one edge and never raise `busy`.
- `out`, `hi` and `lo` have zero combinational latency from the registers; `out` has zero latency from `op`.
- Arithmetic operands are the A and B values at the accept edge. Later changes to A and B have no effect.

## Structure
- A shared package `mips_defs` holds:
  - the MDU op encoding (`MDU_MULT`…`MDU_MTLO`);
  - the default `WIDTH` constant;
  - the default latency constants.
- One sub-module, `mdu_arith`: purely combinational. It computes `{res_hi,res_lo}` from A, B and op, including the divide-by-zero and overflow rules.
- The top-level `mdu` holds:
  - the counter;
  - the pending and HI/LO registers;
  - the accept logic;
  - the `out` mux.

## Test plan
- **Signed multiply:** MULT with A=0xFFFFFFFE (−2), B=3, MULT_CYCLES=5 → `busy` high for exactly 5 cycles, then `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA. MFHI returns 0xFFFFFFFF.
- **Unsigned multiply, signed divide:**
  - MULTU with A=0xFFFFFFFF, B=2 → `hi`=1, `lo`=0xFFFFFFFE.
  - DIV with A=−7, B=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1), after 10 busy cycles.
- **Divide corner cases:**
  - DIVU with A=5, B=0 → `lo`=0xFFFFFFFF, `hi`=5.
  - DIV with A=0x80000000, B=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Start while busy:** during a MULT's busy window, apply MTLO A=0x1234 and a second MULT → both ignored. The final HI/LO equal the first MULT's result, and `busy` falls on schedule.
- **Move to HI/LO:** MTHI A=0xAAAA0000 then MTLO A=0x5555 on consecutive idle cycles → `hi`=0xAAAA0000, `lo`=0x5555, `busy` stays 0.
- **Reset mid-operation:** assert `reset` for one cycle at busy cycle 3 of a DIV → `busy`=0 and `hi`=`lo`=0 on the next cycle. No write-back afterwards.
